// File: rtl/matrix_row_scanner.sv
// Time-multiplexed LED dot-matrix row scanner: NPAT writable glyphs, active-low
// one-hot row drive, pattern switching at frame boundaries and optional blink.
module matrix_row_scanner #(
  parameter int ROWS         = 7,
  parameter int COLS         = 5,
  parameter int NPAT         = 4,
  parameter int SELW         = 2,
  parameter int ROWW         = 3,
  parameter int DIV          = 1000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SELW-1:0] sel,
  input  logic            blink_en,
  input  logic            wr_en,
  input  logic [SELW-1:0] wr_pat,
  input  logic [ROWW-1:0] wr_row,
  input  logic [COLS-1:0] wr_data,
  output logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col,
  output logic            frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]   presc;
  logic [ROWW-1:0] row_idx;
  logic [SELW-1:0] active_sel;
  logic [FW-1:0]   frame_cnt;
  logic            phase;
  logic            tick;
  logic            wrap;
  logic            wr_ok;
  logic [COLS-1:0] mem [NPAT][ROWS];
  logic [COLS-1:0] cur_bits;

  function automatic logic [COLS-1:0] blank_gate(input logic [COLS-1:0] bits,
                                                 input logic en, input logic ph);
    return (en && ph) ? '0 : bits;
  endfunction

  always_comb begin
    tick     = (presc == PW'(DIV - 1));
    wrap     = tick && (row_idx == ROWW'(ROWS - 1));
    wr_ok    = wr_en && (32'(wr_row) < ROWS);
    cur_bits = mem[active_sel][row_idx];
  end

  // Scan timing: prescaler, row index, frame-synchronous select and blink phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      row_idx    <= '0;
      active_sel <= '0;
      frame_cnt  <= '0;
      phase      <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        row_idx <= wrap ? '0 : row_idx + 1'b1;
      if (wrap) begin
        // Latching sel only here keeps a frame from mixing two glyphs.
        active_sel <= sel;
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Pattern register file; out-of-range rows are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NPAT; p++)
        for (int r = 0; r < ROWS; r++)
          mem[p][r] <= '0;
    end else if (wr_ok) begin
      mem[wr_pat][wr_row] <= wr_data;
    end
  end

  // Output stage: registered from the pre-edge state, one cycle behind row_idx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_n      <= '1;
      col        <= '0;
      frame_done <= 1'b0;
    end else begin
      row_n      <= ~(ROWS'(1) << row_idx);
      col        <= blank_gate(cur_bits, blink_en, phase);
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Scoreboard bench for matrix_row_scanner: a cycle-count based reference model
// pushes expected outputs per edge; they are popped and compared after the edge.
module tb_matrix_row_scanner;
  localparam int ROWS = 7;
  localparam int COLS = 5;
  localparam int NPAT = 4;
  localparam int SELW = 2;
  localparam int ROWW = 3;
  localparam int DIV  = 4;
  localparam int BF   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [SELW-1:0] sel = '0;
  logic            blink_en = 1'b0;
  logic            wr_en = 1'b0;
  logic [SELW-1:0] wr_pat = '0;
  logic [ROWW-1:0] wr_row = '0;
  logic [COLS-1:0] wr_data = '0;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col;
  logic            frame_done;

  matrix_row_scanner #(
    .ROWS(ROWS), .COLS(COLS), .NPAT(NPAT), .SELW(SELW), .ROWW(ROWW),
    .DIV(DIV), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .blink_en(blink_en),
    .wr_en(wr_en), .wr_pat(wr_pat), .wr_row(wr_row), .wr_data(wr_data),
    .row_n(row_n), .col(col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS-1:0] row_n;
    logic [COLS-1:0] col;
    logic            fd;
  } exp_t;

  exp_t            sb[$];
  logic [COLS-1:0] mm [NPAT][ROWS];
  logic [SELW-1:0] asel;
  int              cnt;
  int              last_r;
  bit              last_fd;
  int              total = 0;
  int              bad = 0;

  task automatic model_reset();
    for (int p = 0; p < NPAT; p++)
      for (int r = 0; r < ROWS; r++)
        mm[p][r] = '0;
    asel = '0;
    cnt  = 0;
    sb.delete();
  endtask

  // One clock: drive already set, predict, let the edge happen, compare.
  task automatic step(input string tag);
    exp_t e;
    exp_t g;
    int   r;
    bit   tk;
    bit   ph;
    r  = (cnt / DIV) % ROWS;
    tk = (cnt % DIV) == DIV - 1;
    ph = ((cnt / (DIV * ROWS)) / BF) % 2 == 1;
    e.row_n = ~(ROWS'(1) << r);
    e.col   = (blink_en && ph) ? '0 : mm[asel][r];
    e.fd    = tk && (r == ROWS - 1);
    sb.push_back(e);
    last_r  = r;
    last_fd = e.fd;
    if (wr_en && wr_row < ROWS) mm[wr_pat][wr_row] = wr_data;
    if (e.fd) asel = sel;
    cnt++;
    @(posedge clk);
    #1;
    g = sb.pop_front();
    total++;
    if (row_n !== g.row_n) begin
      bad++;
      $display("FAIL %s row_n cnt=%0d got=%h want=%h", tag, cnt, row_n, g.row_n);
    end
    total++;
    if (col !== g.col) begin
      bad++;
      $display("FAIL %s col cnt=%0d got=%h want=%h", tag, cnt, col, g.col);
    end
    total++;
    if (frame_done !== g.fd) begin
      bad++;
      $display("FAIL %s frame_done cnt=%0d got=%b want=%b", tag, cnt, frame_done, g.fd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (row_n !== 7'h7F) begin bad++; $display("FAIL reset row_n got=%h want=7f", row_n); end
    total++;
    if (col !== '0) begin bad++; $display("FAIL reset col got=%h want=00", col); end
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL reset frame_done got=%b want=0", frame_done); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    for (int i = 0; i < 3 * DIV + 2; i++) step("idle");
  endtask

  task automatic test_write_pattern();
    logic [COLS-1:0] pat [ROWS];
    pat = '{5'h11, 5'h1F, 5'h0A, 5'h15, 5'h04, 5'h1B, 5'h0E};
    for (int i = 0; i < ROWS; i++) begin
      wr_en = 1'b1; wr_pat = '0; wr_row = ROWW'(i); wr_data = pat[i];
      step("wr_p0");
    end
    for (int i = 0; i < ROWS; i++) begin
      wr_en = 1'b1; wr_pat = 2'd2; wr_row = ROWW'(i); wr_data = ~pat[i];
      step("wr_p2");
    end
    wr_en = 1'b0;
    for (int i = 0; i < DIV * ROWS + DIV; i++) step("show_p0");
  endtask

  task automatic test_sel_switch();
    for (int i = 0; i < 2 * DIV * ROWS && ((cnt / DIV) % ROWS) != 3; i++) step("seek_r3");
    sel = 2'd2;
    for (int i = 0; i < 2 * DIV * ROWS; i++) step("sel_sw");
  endtask

  task automatic test_blink();
    blink_en = 1'b1;
    for (int i = 0; i < 5 * DIV * ROWS; i++) step("blink");
    blink_en = 1'b0;
  endtask

  task automatic test_write_edge();
    int r;
    wr_en = 1'b1; wr_pat = asel; wr_row = 3'd7; wr_data = 5'h1F;
    step("wr_oob");
    wr_en = 1'b0;
    for (int i = 0; i < DIV * ROWS; i++) step("after_oob");
    if (cnt % DIV >= DIV - 2) begin
      step("align");
      step("align");
    end
    r = (cnt / DIV) % ROWS;
    wr_en = 1'b1; wr_pat = asel; wr_row = ROWW'(r); wr_data = ~mm[asel][r];
    step("wr_live");
    wr_en = 1'b0;
    for (int i = 0; i < DIV; i++) step("live_upd");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 150; i++) begin
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_pat   = SELW'($urandom_range(0, NPAT - 1));
      wr_row   = ROWW'($urandom_range(0, 7));
      wr_data  = COLS'($urandom);
      sel      = SELW'($urandom_range(0, NPAT - 1));
      blink_en = ($urandom_range(0, 3) == 0);
      step("b2b");
    end
    wr_en = 1'b0;
    blink_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 2'd1;
    for (int i = 0; i < 3 * DIV * ROWS && !(last_r == 4 && (cnt % DIV) == 2); i++) step("seek_r4");
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (row_n !== 7'h7F) begin bad++; $display("FAIL rst_mid row_n got=%h want=7f", row_n); end
    total++;
    if (col !== '0) begin bad++; $display("FAIL rst_mid col got=%h want=00", col); end
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_mid frame_done got=%b want=0", frame_done); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DIV * ROWS + 2 * DIV; i++) step("restart");
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_write_pattern();
    test_sel_switch();
    test_blink();
    test_write_edge();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
